load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 128, giving the number of 32-bit words in the attached data memory.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  core access request.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result, extended.
- ready  out  1  final cycle of the access.
- fault  out  1  access rejected, valid with ready.
- mem_we  out  1  to memory WE.
- mem_a  out  32  word address to memory A.
- mem_wd  out  32  to memory WD.
- mem_rd  in  32  from memory RD; combinational read.

Function
REQ-003 mem_a SHALL be {2'b00, word index}, where the word index is addr[31:2] for the first word and addr[31:2]+1 for the second word.
REQ-004 The core SHALL hold req_valid, req_we, funct3, addr and wdata stable until ready; ready SHALL pulse for one cycle, and the FSM SHALL return to IDLE on the following edge.
REQ-005 The FSM SHALL have states IDLE, RD0, WR0, RD1 and WR1; IDLE serves single-cycle accesses combinationally.
REQ-006 Aligned loads, meaning the access lies wholly inside one word: ready=1 in the request cycle, mem_we=0, and rdata = selected byte/half, sign-extended for B/H and zero-extended for BU/HU.
REQ-007 Aligned SW: mem_we=1, mem_wd=wdata and ready=1 in the request cycle.
REQ-008 Aligned SB/SH shall take 2 cycles:
- Cycle 0 (IDLE→WR0): read word, register the merged word (mem_rd with the lanes replaced), mem_we=0.
- Cycle 1 (WR0): mem_we=1, mem_wd = registered merged word, ready=1.
- The registered merge breaks the mem_rd→mem_wd path.
REQ-009 A misaligned access is one whose bytes span two words (H at offset 3; W at offset ≠0); handling is per REQ-015.
REQ-010 Fault conditions: invalid funct3 (011, 110, 111), word index ≥ MEM_WORDS, or a misaligned access whose second word index ≥ MEM_WORDS (no wrap).
- Response: fault=1, ready=1 in the request cycle, mem_we=0, rdata=0.
REQ-011 Byte order SHALL be little-endian: byte k of the word is bits [8k+7:8k].
REQ-012 If req_valid deasserts in a non-IDLE state, the FSM SHALL go to IDLE on the next edge and issue no further writes; a completed WR0 write persists.
REQ-013 In IDLE with req_valid=0: mem_we=0, ready=0, fault=0, rdata=0.

Reset
REQ-014 On rst=0, asynchronously:
- The FSM SHALL enter IDLE and clear the merge and low-word registers to 0.
- mem_we, ready, fault and rdata SHALL go to 0 immediately, including mid-access.

Configuration
REQ-015 Macro LSU_MISALIGN_EN SHALL select misaligned handling.
- Defined, misaligned loads: 2 cycles. RD0 latches word0; RD1 combines the latched word0 with live mem_rd (word1) and asserts ready.
- Defined, misaligned stores: 4 cycles, RD0→WR0→RD1→WR1, each word read-merge-write; ready only in WR1.
- Undefined: every misaligned access SHALL fault per REQ-010, and states RD1/WR1 SHALL NOT be built.

Verification
REQ-016 Memory word5=0x8899AABB, LB addr 0x17 → rdata=0xFFFFFF88, ready=1 in cycle 0; LBU at the same address → 0x00000088.
REQ-017 SB wdata=0x11 addr 0x14, word5=0x8899AABB → cycle 0: mem_we=0; cycle 1: mem_we=1, mem_a=5, mem_wd=0x8899AA11, ready=1.
REQ-018 LSU_MISALIGN_EN defined, word5=0x8899AABB, word6=0x44332211, LW addr 0x16 → cycle 1: rdata=0x22118899, ready=1; mem_we=0 throughout.
REQ-019 LSU_MISALIGN_EN undefined, LW addr 0x16 → cycle 0: fault=1, ready=1, rdata=0; mem_we is never 1.
REQ-020 MEM_WORDS=128, SW addr 0x200 → fault=1, ready=1, mem_we=0; LH addr 0x1FF → fault.
REQ-021 rst=0 during SB cycle 0 → mem_we=0 and state IDLE immediately; after release, a repeat of the REQ-017 SB → the REQ-017 response.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Connects a core's load/store requests to a single-port word memory with a combinational read.
//   Aligned loads and aligned SW complete in the request cycle.
//   Aligned SB/SH take two cycles: read, merge into a register, then write.
//   Accesses are rejected in the request cycle when:
//     - funct3 is not a defined encoding;
//     - the word index is out of range;
//     - a misaligned access is not supported, or its second word is out of range.
//
// Configuration macro: LSU_MISALIGN_EN
//   Defined   : misaligned loads take 2 cycles (IDLE/RD0 -> RD1).
//               Misaligned stores take 4 cycles (RD0 -> WR0 -> RD1 -> WR1).
//   Undefined : every misaligned access faults, and RD1/WR1 do not exist.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   req_valid  core access request; fields held stable until ready
//   req_we     1 = store, 0 = load
//   funct3     000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr       byte address
//   wdata      store data, right-aligned
//   rdata      load result, sign/zero extended; 0 when no load completes
//   ready      final cycle of the access (one-cycle pulse)
//   fault      access rejected, valid with ready
//   mem_we     memory write enable
//   mem_a      word address to memory ({2'b00, word index})
//   mem_wd     memory write data
//   mem_rd     memory read data (combinational)
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD0  = 3'd1;
  localparam logic [2:0] WR0  = 3'd2;
`ifdef LSU_MISALIGN_EN
  localparam logic [2:0] RD1  = 3'd3;
  localparam logic [2:0] WR1  = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  // RD0 is never registered: it is the request cycle of a multi-cycle access, served from IDLE.
  logic [2:0]  phase;
  logic [31:0] merge_q, merge_d;
`ifdef LSU_MISALIGN_EN
  logic [31:0] low_q, low_d;
`endif

  // Request decode
  logic [1:0]  off;
  logic [1:0]  sz;
  logic        sign_ext;
  logic        f3_ok;
  logic [29:0] idx0;
  logic        idx0_oob;
  logic        misaligned;
  logic        misalign_fault;
  logic        req_fault;
  logic        multi_cycle;
  logic [3:0]  size_mask;
  logic [3:0]  be0;
  logic [31:0] wd0;

  assign off      = addr[1:0];
  assign sz       = funct3[1:0];
  assign sign_ext = ~funct3[2];
  assign idx0     = addr[31:2];

  always_comb begin
    case (funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
      default:                                f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign misaligned = ((sz == 2'b01) && (off == 2'b11)) || ((sz == 2'b10) && (off != 2'b00));
  assign idx0_oob   = ({2'b00, idx0} >= MEM_WORDS);

`ifdef LSU_MISALIGN_EN
  logic [29:0] idx1;
  logic        idx1_oob;
  logic [7:0]  be_all;
  logic [63:0] wd_all;
  logic [3:0]  be1;
  logic [31:0] wd1;

  assign idx1     = idx0 + 30'd1;
  // Computed one bit wider than the index so the last word never wraps to word 0.
  assign idx1_oob = (({2'b00, idx0} + 32'd1) >= MEM_WORDS);
  assign misalign_fault = misaligned & idx1_oob;

  // Byte lanes and data across the two-word window; low word first.
  assign be_all = {4'b0000, size_mask} << off;
  assign wd_all = {32'h0, wdata} << {off, 3'b000};
  assign be0    = be_all[3:0];
  assign be1    = be_all[7:4];
  assign wd0    = wd_all[31:0];
  assign wd1    = wd_all[63:32];
`else
  assign misalign_fault = misaligned;
  assign be0            = size_mask << off;
  assign wd0            = wdata << {off, 3'b000};
`endif

  assign req_fault   = ~f3_ok | idx0_oob | misalign_fault;
  assign multi_cycle = misaligned | (req_we & (sz != 2'b10));

  // Load data path
  logic [31:0] ld_word;
  logic [31:0] ld_val;

`ifdef LSU_MISALIGN_EN
  logic [63:0] ld_pair;
  // In RD1 the low word comes from the latch and the high word is live on mem_rd.
  assign ld_pair = {mem_rd, (state_q == RD1) ? low_q : mem_rd};
  assign ld_word = ld_pair[{1'b0, off, 3'b000} +: 32];
`else
  assign ld_word = mem_rd >> {off, 3'b000};
`endif

  always_comb begin
    case (sz)
      2'b00:   ld_val = {{24{sign_ext & ld_word[7]}}, ld_word[7:0]};
      2'b01:   ld_val = {{16{sign_ext & ld_word[15]}}, ld_word[15:0]};
      default: ld_val = ld_word;
    endcase
  end

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return res;
  endfunction

  // FSM next state and outputs
  logic        mem_we_c;
  logic        ready_c;
  logic        fault_c;
  logic        load_out;
  logic [29:0] mem_idx;
  logic [31:0] mem_wd_c;

  assign phase = ((state_q == IDLE) && req_valid && !req_fault && multi_cycle) ? RD0 : state_q;

  always_comb begin
    state_d  = state_q;
    merge_d  = merge_q;
`ifdef LSU_MISALIGN_EN
    low_d    = low_q;
`endif
    mem_we_c = 1'b0;
    ready_c  = 1'b0;
    fault_c  = 1'b0;
    load_out = 1'b0;
    mem_idx  = idx0;
    mem_wd_c = merge_q;

    case (phase)
      IDLE: begin
        // Only single-cycle work reaches here: faults, aligned loads, aligned SW.
        if (req_valid) begin
          ready_c = 1'b1;
          if (req_fault) begin
            fault_c = 1'b1;
          end else if (req_we) begin
            mem_we_c = 1'b1;
            mem_wd_c = wdata;
          end else begin
            load_out = 1'b1;
          end
        end
      end
      RD0: begin
        if (req_we) begin
          merge_d = merge_lanes(mem_rd, wd0, be0);
          state_d = WR0;
        end
`ifdef LSU_MISALIGN_EN
        else begin
          low_d   = mem_rd;
          state_d = RD1;
        end
`endif
      end
      WR0: begin
        state_d = IDLE;
        if (req_valid) begin
          mem_we_c = 1'b1;
`ifdef LSU_MISALIGN_EN
          if (misaligned) begin
            state_d = RD1;
          end else begin
            ready_c = 1'b1;
          end
`else
          ready_c = 1'b1;
`endif
        end
      end
`ifdef LSU_MISALIGN_EN
      RD1: begin
        mem_idx = idx1;
        state_d = IDLE;
        if (req_valid) begin
          if (req_we) begin
            merge_d = merge_lanes(mem_rd, wd1, be1);
            state_d = WR1;
          end else begin
            ready_c  = 1'b1;
            load_out = 1'b1;
          end
        end
      end
      WR1: begin
        mem_idx = idx1;
        state_d = IDLE;
        if (req_valid) begin
          mem_we_c = 1'b1;
          ready_c  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      merge_q <= '0;
`ifdef LSU_MISALIGN_EN
      low_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
`ifdef LSU_MISALIGN_EN
      low_q   <= low_d;
`endif
    end
  end

  // Strobes and read data are forced low while reset is asserted, even mid-access.
  assign mem_we = mem_we_c & rst;
  assign ready  = ready_c & rst;
  assign fault  = fault_c & rst;
  assign rdata  = (load_out & rst) ? ld_val : 32'h0;
  assign mem_a  = {2'b00, mem_idx};
  assign mem_wd = mem_wd_c;

endmodule
